// File: rtl/apb_pkg.sv
// Shared types and constants for the APB completer memory.
// Provides the FSM state type, the pprot privilege bit and a byte-offset helper.
package apb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_slave_state_e;

    localparam int PPROT_PRIV = 0;

    // Number of byte-offset bits inside one data word.
    function automatic int offs_w(input int data_width);
        return (data_width > 8) ? $clog2(data_width / 8) : 0;
    endfunction

    localparam int OFFS_W_DEFAULT = offs_w(32);

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB4 completer-side bus bundle.
// master drives psel/penable/pwrite/paddr/pprot/pwdata/pstrb; slave returns prdata/pready/pslverr.
interface apb_slave_mem_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    localparam int BYTES_PER_WORD = DATA_WIDTH / 8;

    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [ADDR_WIDTH-1:0]     paddr;
    logic [2:0]                pprot;
    logic [DATA_WIDTH-1:0]     pwdata;
    logic [BYTES_PER_WORD-1:0] pstrb;
    logic [DATA_WIDTH-1:0]     prdata;
    logic                      pready;
    logic                      pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pprot, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pprot, pwdata, pstrb,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_slave_regfile.sv
// Word-organised storage: byte-strobe write port and registered read port.
// Ports: pclk/preset, rd_en/rd_zero/rd_idx -> rd_data, wr_en/wr_idx/wr_data/wr_strb.
module apb_slave_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int IW         = 6
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic                      rd_en,
    input  logic                      rd_zero,
    input  logic [IW-1:0]             rd_idx,
    output logic [DATA_WIDTH-1:0]     rd_data,
    input  logic                      wr_en,
    input  logic [IW-1:0]             wr_idx,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [DATA_WIDTH/8-1:0]   wr_strb
);

    localparam int BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem[w] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (wr_en) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (wr_strb[b]) begin
                        mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                    end
                end
            end
            // rd_zero covers errors (incl. out-of-range index) and writes.
            if (rd_en) begin
                rd_data <= rd_zero ? '0 : mem[rd_idx];
            end
        end
    end

endmodule

// File: rtl/apb_slave_mem.sv
// APB4 completer with word memory, byte strobes, wait states and error decode.
// Ports: pclk, preset (async, active-high), bus (apb_slave_mem_if.slave).
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int DEPTH          = 64,
    parameter int WAIT_STATES    = 0,
    parameter int PRIV_BASE      = 48,
    parameter int BYTES_PER_WORD = DATA_WIDTH / 8
) (
    input  logic             pclk,
    input  logic             preset,
    apb_slave_mem_if.slave   bus
);

    localparam int OFFS_W = offs_w(DATA_WIDTH);
    localparam int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK =
        ADDR_WIDTH'(BYTES_PER_WORD - 1);

    apb_slave_state_e          state;
    logic [3:0]                wait_cnt;
    logic                      err_q;
    logic                      write_q;
    logic [IW-1:0]             idx_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [BYTES_PER_WORD-1:0] strb_q;

    logic [ADDR_WIDTH-1:0]     idx_c;
    int                        idx_i;
    logic                      err_c;
    logic                      setup;
    logic                      complete;
    logic                      wr_en;
    logic                      unused_pprot;

    assign idx_c = bus.paddr >> OFFS_W;
    assign unused_pprot = ^bus.pprot[2:1];

    always_comb begin
        idx_i = int'(idx_c);
        err_c = (idx_i >= DEPTH)
              || ((bus.paddr & OFF_MASK) != '0)
              || ((idx_i >= PRIV_BASE) && !bus.pprot[PPROT_PRIV]);
    end

    assign setup    = (state == IDLE) && bus.psel && !bus.penable;
    assign complete = (state == ACCESS) && bus.psel && bus.penable
                    && (wait_cnt == 4'd0);
    assign wr_en    = complete && write_q && !err_q;

    // Outputs decode registered state only; no input-to-output path.
    assign bus.pready  = (state == ACCESS) && (wait_cnt == 4'd0);
    assign bus.pslverr = bus.pready && err_q;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            err_q    <= 1'b0;
            write_q  <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            strb_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (setup) begin
                        state    <= ACCESS;
                        wait_cnt <= 4'(WAIT_STATES);
                        err_q    <= err_c;
                        write_q  <= bus.pwrite;
                        idx_q    <= IW'(idx_c);
                        wdata_q  <= bus.pwdata;
                        strb_q   <= bus.pstrb;
                    end
                end
                ACCESS: begin
                    // psel dropping before completion is an abort.
                    if (!bus.psel || complete) begin
                        state <= IDLE;
                    end else if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
            endcase
        end
    end

    apb_slave_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IW         (IW)
    ) u_regfile (
        .pclk    (pclk),
        .preset  (preset),
        .rd_en   (setup),
        .rd_zero (err_c || bus.pwrite),
        .rd_idx  (IW'(idx_c)),
        .rd_data (bus.prdata),
        .wr_en   (wr_en),
        .wr_idx  (idx_q),
        .wr_data (wdata_q),
        .wr_strb (strb_q)
    );

endmodule

// File: tb/tb_apb_slave_mem.sv
// Self-checking bench for apb_slave_mem: reference model plus directed vectors.
// Two instances: zero wait states (model-checked every cycle) and three wait states.
module tb_apb_slave_mem;

    logic pclk = 1'b0;
    logic preset = 1'b1;
    always #5 pclk = ~pclk;

    logic        psel0 = 1'b0;
    logic        psel3 = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [9:0]  paddr = '0;
    logic [2:0]  pprot = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;

    apb_slave_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) if0 ();
    apb_slave_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) if3 ();

    assign if0.psel    = psel0;
    assign if0.penable = penable;
    assign if0.pwrite  = pwrite;
    assign if0.paddr   = paddr;
    assign if0.pprot   = pprot;
    assign if0.pwdata  = pwdata;
    assign if0.pstrb   = pstrb;

    assign if3.psel    = psel3;
    assign if3.penable = penable;
    assign if3.pwrite  = pwrite;
    assign if3.paddr   = paddr;
    assign if3.pprot   = pprot;
    assign if3.pwdata  = pwdata;
    assign if3.pstrb   = pstrb;

    apb_slave_mem #(.WAIT_STATES(0)) dut0 (
        .pclk   (pclk),
        .preset (preset),
        .bus    (if0.slave)
    );

    apb_slave_mem #(.WAIT_STATES(3)) dut3 (
        .pclk   (pclk),
        .preset (preset),
        .bus    (if3.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model of dut0: one pending transfer, memory as an array.
    logic [31:0] m_mem [64];
    bit          m_active = 1'b0;
    bit          m_err = 1'b0;
    bit          m_wr = 1'b0;
    int          m_idx = 0;
    logic [31:0] m_rdata = '0;
    logic [31:0] m_wdata = '0;
    logic [3:0]  m_strb = '0;

    task automatic model_step();
        if (preset) begin
            for (int i = 0; i < 64; i++) m_mem[i] = '0;
            m_active = 1'b0;
            m_err = 1'b0;
            m_rdata = '0;
        end else if (!m_active) begin
            if (psel0 && !penable) begin
                m_idx = int'(paddr) / 4;
                m_err = (m_idx >= 64) || (int'(paddr) % 4 != 0)
                     || (m_idx >= 48 && !pprot[0]);
                if (m_err || pwrite) m_rdata = '0;
                else m_rdata = m_mem[m_idx];
                m_wr = pwrite;
                m_wdata = pwdata;
                m_strb = pstrb;
                m_active = 1'b1;
            end
        end else if (!psel0) begin
            m_active = 1'b0;
        end else if (penable) begin
            if (m_wr && !m_err) begin
                for (int b = 0; b < 4; b++)
                    if (m_strb[b]) m_mem[m_idx][8*b +: 8] = m_wdata[8*b +: 8];
            end
            m_active = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(posedge pclk or posedge preset);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge pclk);
            if (!preset) begin
                chk("model_pready", 32'(if0.pready), 32'(m_active));
                chk("model_pslverr", 32'(if0.pslverr), 32'(m_active && m_err));
                chk("model_prdata", if0.prdata, m_rdata);
            end
        end
    end

    function automatic logic rdy(input int w);
        return (w == 0) ? if0.pready : if3.pready;
    endfunction

    task automatic xfer(input int w, input bit wr, input logic [9:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic [2:0] p, output logic [31:0] rd,
                        output logic er, output int acc);
        bit done;
        if (w == 0) psel0 = 1'b1;
        else psel3 = 1'b1;
        penable = 1'b0;
        pwrite = wr;
        paddr = a;
        pwdata = d;
        pstrb = s;
        pprot = p;
        @(posedge pclk);
        #1 penable = 1'b1;
        acc = 0;
        rd = '0;
        er = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge pclk);
            acc++;
            if (rdy(w)) begin
                rd = (w == 0) ? if0.prdata : if3.prdata;
                er = (w == 0) ? if0.pslverr : if3.pslverr;
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout addr=%h actual=no_pready required=pready", a);
        end
        @(posedge pclk);
        #1;
        psel0 = 1'b0;
        psel3 = 1'b0;
        penable = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          acc;
    logic [31:0] bb [4];

    initial begin
        bb[0] = 32'hA0B0C000;
        bb[1] = 32'hA0B0C001;
        bb[2] = 32'hA0B0C002;
        bb[3] = 32'hA0B0C003;

        #2;
        chk("reset_pready", 32'(if0.pready), 32'd0);
        chk("reset_pslverr", 32'(if0.pslverr), 32'd0);
        chk("reset_prdata", if0.prdata, 32'd0);
        #10 preset = 1'b0;
        @(posedge pclk);
        #1;

        xfer(0, 1, 10'h00C, 32'hDEADBEEF, 4'hF, 3'd0, rd, er, acc);
        chk("wr0C_err", 32'(er), 32'd0);
        chk("wr0C_lat", 32'(acc), 32'd1);
        chk("pin_model_m3", m_mem[3], 32'hDEADBEEF);
        xfer(0, 0, 10'h00C, 32'h0, 4'h0, 3'd0, rd, er, acc);
        chk("rd0C_data", rd, 32'hDEADBEEF);
        chk("rd0C_err", 32'(er), 32'd0);
        chk("rd0C_lat", 32'(acc), 32'd1);

        xfer(0, 1, 10'h010, 32'hFFFFFFFF, 4'hF, 3'd0, rd, er, acc);
        xfer(0, 1, 10'h010, 32'h00000000, 4'b0101, 3'd0, rd, er, acc);
        xfer(0, 0, 10'h010, 32'h0, 4'h0, 3'd0, rd, er, acc);
        chk("strb_data", rd, 32'hFF00FF00);
        chk("pin_model_m4", m_mem[4], 32'hFF00FF00);

        xfer(0, 0, 10'h100, 32'h0, 4'h0, 3'd0, rd, er, acc);
        chk("oor_err", 32'(er), 32'd1);
        chk("oor_data", rd, 32'd0);
        xfer(0, 1, 10'h00E, 32'h55555555, 4'hF, 3'd0, rd, er, acc);
        chk("misal_err", 32'(er), 32'd1);
        xfer(0, 0, 10'h00C, 32'h0, 4'h0, 3'd0, rd, er, acc);
        chk("misal_nochg", rd, 32'hDEADBEEF);
        xfer(0, 1, 10'h0C0, 32'hA5A5A5A5, 4'hF, 3'd0, rd, er, acc);
        chk("priv_wr_err", 32'(er), 32'd1);
        xfer(0, 0, 10'h0C0, 32'h0, 4'h0, 3'd1, rd, er, acc);
        chk("priv_nochg", rd, 32'd0);
        chk("priv_rd_ok", 32'(er), 32'd0);
        xfer(0, 1, 10'h0C0, 32'h12345678, 4'hF, 3'd1, rd, er, acc);
        chk("priv_wr_ok", 32'(er), 32'd0);
        xfer(0, 0, 10'h0C0, 32'h0, 4'h0, 3'd1, rd, er, acc);
        chk("priv_rd_data", rd, 32'h12345678);
        xfer(0, 0, 10'h0C0, 32'h0, 4'h0, 3'd0, rd, er, acc);
        chk("priv_rd_err", 32'(er), 32'd1);
        chk("priv_rd_zero", rd, 32'd0);

        xfer(3, 0, 10'h004, 32'h0, 4'h0, 3'd0, rd, er, acc);
        chk("ws3_access_cycles", 32'(acc), 32'd4);
        chk("ws3_err", 32'(er), 32'd0);

        psel3 = 1'b1;
        penable = 1'b0;
        pwrite = 1'b1;
        paddr = 10'h004;
        pwdata = 32'hCAFEF00D;
        pstrb = 4'hF;
        pprot = 3'd0;
        @(posedge pclk);
        #1 penable = 1'b1;
        @(negedge pclk);
        chk("abort_wait1", 32'(if3.pready), 32'd0);
        @(posedge pclk);
        #1;
        psel3 = 1'b0;
        penable = 1'b0;
        @(posedge pclk);
        #1;
        xfer(3, 0, 10'h004, 32'h0, 4'h0, 3'd0, rd, er, acc);
        chk("abort_nowrite", rd, 32'd0);
        chk("abort_idle_lat", 32'(acc), 32'd4);

        xfer(3, 1, 10'h008, 32'h0BADCAFE, 4'hF, 3'd0, rd, er, acc);
        xfer(3, 0, 10'h008, 32'h0, 4'h0, 3'd0, rd, er, acc);
        chk("ws3_rd08", rd, 32'h0BADCAFE);

        for (int i = 0; i < 4; i++) begin
            xfer(0, 1, 10'(4 * i), bb[i], 4'hF, 3'd0, rd, er, acc);
            chk("b2b_wr_lat", 32'(acc), 32'd1);
        end
        for (int i = 0; i < 4; i++) begin
            xfer(0, 0, 10'(4 * i), 32'h0, 4'h0, 3'd0, rd, er, acc);
            chk("b2b_rd_lat", 32'(acc), 32'd1);
            chk("b2b_rd_data", rd, bb[i]);
        end

        psel0 = 1'b1;
        penable = 1'b0;
        pwrite = 1'b1;
        paddr = 10'h00C;
        pwdata = 32'h77777777;
        pstrb = 4'hF;
        @(posedge pclk);
        #1 penable = 1'b1;
        #2;
        chk("pre_rst_pready", 32'(if0.pready), 32'd1);
        chk("pre_rst_prdata3", if3.prdata, 32'h0BADCAFE);
        preset = 1'b1;
        #1;
        chk("rst_pready", 32'(if0.pready), 32'd0);
        chk("rst_pslverr", 32'(if0.pslverr), 32'd0);
        chk("rst_prdata", if0.prdata, 32'd0);
        chk("rst_prdata3", if3.prdata, 32'd0);
        psel0 = 1'b0;
        penable = 1'b0;
        #3 preset = 1'b0;
        @(posedge pclk);
        #1;
        xfer(0, 0, 10'h00C, 32'h0, 4'h0, 3'd0, rd, er, acc);
        chk("post_rst_rd0C", rd, 32'd0);
        chk("pin_model_rst", m_mem[3], 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB4 completer that sits directly downstream of the team's APB master: it receives one bit of the master's `psel` vector plus the shared `paddr/pprot/penable/pwrite/pwdata/pstrb` bus. It returns `prdata/pready/pslverr`, which the master forwards to its requester. Internally it is a word-organised register memory with byte-strobe writes and a programmable number of wait states. It reports errors for out-of-range, misaligned and privilege-violating accesses.

## Interface
- `DATA_WIDTH`, 32: width of `pwdata`/`prdata`; must be a multiple of 8.
- `ADDR_WIDTH`, 10: byte-address width of `paddr`.
- `DEPTH`, 64: number of data words; must satisfy `DEPTH*BYTES_PER_WORD <= 2**ADDR_WIDTH`.
- `WAIT_STATES`, 0: pready-low cycles inserted in each access phase (0..15).
- `PRIV_BASE`, 48: first word index reserved for privileged access; words `>= PRIV_BASE` require `pprot[0]=1`.
- `BYTES_PER_WORD`, `DATA_WIDTH/8`: derived; do not override.
- `pclk`, in, 1: clock.
- `preset`, in, 1: reset. **One clock; reset is asynchronous and active-high.**
- `psel`, in, 1: this completer's select bit.
- `penable`, in, 1: access-phase flag.
- `pwrite`, in, 1: 1 = write, 0 = read.
- `paddr`, in, `ADDR_WIDTH`: byte address.
- `pprot`, in, 3: protection; only bit 0 (privileged) is used.
- `pwdata`, in, `DATA_WIDTH`: write data.
- `pstrb`, in, `BYTES_PER_WORD`: write byte enables; ignored on reads.
- `prdata`, out, `DATA_WIDTH`: read data; valid while `pready=1` on a read.
- `pready`, out, 1: transfer completes this cycle.
- `pslverr`, out, 1: error response; valid only while `pready=1`.

## Operation
- **Word index:** `idx = paddr >> log2(BYTES_PER_WORD)`.
- **Error conditions:** any of `idx >= DEPTH`, nonzero `paddr[log2(BYTES_PER_WORD)-1:0]`, or (`idx >= PRIV_BASE` and `pprot[0]=0`).
- **States:** FSM with `IDLE` and `ACCESS`.
- **IDLE:**
  - Detect setup (`psel=1`, `penable=0`).
  - At that edge: go to `ACCESS`, load `wait_cnt = WAIT_STATES`, register `err`, register `prdata` (memory word, or 0 on error or write), and latch `paddr/pwrite/pwdata/pstrb`.
- **ACCESS:**
  - `pready = (wait_cnt==0)`, a pure decode of registers.
  - While `wait_cnt != 0` and `psel=1`, decrement by 1 per cycle.
- **Completion edge** (`psel & penable & pready`):
  - Write with `err=0`: for each byte `b` with `pstrb[b]=1`, the byte is updated from `pwdata`; other bytes are unchanged.
  - Write with `err=1`: no memory change.
  - FSM returns to `IDLE`.
- **pslverr** equals `err` while `pready=1`, and is 0 otherwise.
- **prdata** holds its last value until the next setup edge.
- **Protocol abort:** `psel` dropping while in `ACCESS` before completion returns the FSM to `IDLE` with no write.
- **Reset (asynchronous, active-high):**
  - FSM goes to `IDLE`, `wait_cnt=0`, memory all zero.
  - Outputs: `prdata=0`, `pready=0`, `pslverr=0`.
  - Reset mid-transfer discards the transfer; memory returns to zero.

## Timing
- **Latency:** setup cycle, then `WAIT_STATES+1` access cycles. With `WAIT_STATES=0`, `pready=1` in the first access cycle.
- **Back-to-back:** the master issues setup in the cycle after completion. `IDLE` accepts it immediately, with no bubble beyond the APB-mandated setup cycle.
- **Memory timing:** the memory read is synchronous at the setup edge. A write at completion edge N is visible to a read whose setup edge is later than N.
- **Read-during-write:** cannot occur, because a single completer handles one transfer at a time.
- **Inputs:** no combinational path from inputs to `pready` or `pslverr`.

## Structure
- **Package `apb_pkg`:** `apb_slave_state_e {IDLE, ACCESS}`, the `PPROT_PRIV=0` bit index, and a `clog2`-based helper constant for byte-offset width.
- **Sub-module `apb_slave_regfile`:**
  - `DEPTH x DATA_WIDTH` array with a byte-strobe write port and a registered read port.
  - Asynchronous clear on `preset`.
  - Holds all storage; `apb_slave_mem` holds the FSM, the wait counter and error decode.

## Test plan
All scenarios use defaults unless stated; byte addresses are in hex.
- **Full write then read:** write `0x0C` = `0xDEADBEEF` with `pstrb=4'hF`, `pprot=0`, then read `0x0C` → read returns `0xDEADBEEF`, `pslverr=0`, `pready` in the first access cycle.
- **Partial strobe:** write `0x10` = `0xFFFFFFFF`, then write `0x10` = `0x00000000` with `pstrb=4'b0101` → read returns `0xFF00FF00`.
- **Errors:** each of the following returns `pslverr=1` with `pready=1`, leaves memory unchanged, and returns read data `0`:
  - read `0x100` (`idx=64`);
  - write `0x0E` (misaligned);
  - write `0xC0` with `pprot=0`.
  - Write `0xC0` with `pprot=3'b001` → succeeds.
- **Wait states:** `WAIT_STATES=3`, read `0x04` → `pready` low for exactly 3 access cycles, high on the 4th. An abort (`psel` dropped) in the 2nd access cycle → FSM returns to `IDLE` and no write occurs.
- **Back-to-back:** four writes to `0x00`–`0x0C` then four reads with no idle cycles → each transfer takes 2 cycles and the data matches.
- **Reset mid-operation:** assert `preset` asynchronously in the middle of a write's access phase → `pready`, `pslverr` and `prdata` go to 0 immediately, and a subsequent read of `0x0C` returns `0`.
